// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: pointer type, depth helper and Gray/binary conversions
// used by both the read-side and write-side pointer controllers.
package fifo_pkg;

    localparam int FIFO_ADDRSIZE = 4;

    typedef logic [FIFO_ADDRSIZE:0] ptr_t;

    function automatic int fifo_depth(input int addrsize);
        return 1 << addrsize;
    endfunction

    // Both conversions are width-agnostic: zero-extended upper bits leave the result unchanged.
    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] gray);
        logic [31:0] bin;
        bin[31] = gray[31];
        for (int i = 30; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/gray2bin.sv
// Gray-to-binary converter: each binary bit is the XOR of all Gray bits at or above it.
module gray2bin #(
    parameter int W = 5
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    for (genvar i = 0; i < W; i++) begin : g_bit
        assign bin[i] = ^gray[W-1:i];
    end

endmodule

// File: rtl/rptr_empty_lvl.sv
// Read-domain pointer/flag controller: Gray/binary read pointers, look-ahead empty, fill level,
// almost-empty. Define RPTR_UNDERFLOW_EN to add the sticky underflow flag.
module rptr_empty_lvl
    import fifo_pkg::*;
#(
    parameter int ADDRSIZE  = FIFO_ADDRSIZE,
    parameter int AE_THRESH = 2
) (
    input  logic                rclk,
    input  logic                rrst_n,
    input  logic                rinc,
    input  logic [ADDRSIZE:0]   wptr_sync,
    input  logic                uflow_clr,
    output logic [ADDRSIZE:0]   rptr,
    output logic [ADDRSIZE-1:0] raddr,
    output logic                rd_fire,
    output logic                empty,
    output logic                almost_empty,
    output logic [ADDRSIZE:0]   rlevel,
    output logic                uflow
);

    localparam int                DEPTH  = fifo_depth(ADDRSIZE);
    localparam logic [ADDRSIZE:0] AE_LVL = (ADDRSIZE + 1)'(AE_THRESH);

    if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_thresh
        $error("rptr_empty_lvl: AE_THRESH must lie in 0..DEPTH-1");
    end

    logic [ADDRSIZE:0] rbin;
    logic [ADDRSIZE:0] rbin_next;
    logic [ADDRSIZE:0] rptr_next;
    logic [ADDRSIZE:0] wbin_sync;
    logic [ADDRSIZE:0] level_next;

    gray2bin #(.W(ADDRSIZE + 1)) u_wptr_g2b (
        .gray (wptr_sync),
        .bin  (wbin_sync)
    );

    assign rd_fire    = rinc & ~empty;
    assign rbin_next  = rbin + {{ADDRSIZE{1'b0}}, rd_fire};
    assign rptr_next  = (rbin_next >> 1) ^ rbin_next;
    // Modular subtraction keeps the level correct across the pointer wrap; a full FIFO reads DEPTH.
    assign level_next = wbin_sync - rbin_next;
    assign raddr      = rbin[ADDRSIZE-1:0];

    // NOTE: non-blocking assignments so every flop samples the pre-edge values of its peers.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin         <= '0;
            rptr         <= '0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
            rlevel       <= '0;
        end else begin
            rbin         <= rbin_next;
            rptr         <= rptr_next;
            empty        <= (rptr_next == wptr_sync);
            almost_empty <= (level_next <= AE_LVL);
            rlevel       <= level_next;
        end
    end

`ifdef RPTR_UNDERFLOW_EN
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            uflow <= 1'b0;
        end else if (rinc & empty) begin
            uflow <= 1'b1;
        end else if (uflow_clr) begin
            uflow <= 1'b0;
        end
    end
`else
    logic unused_uflow_clr;

    assign uflow            = 1'b0;
    assign unused_uflow_clr = uflow_clr;
`endif

endmodule

// File: tb/tb_rptr_empty_lvl.sv
// Self-checking bench for rptr_empty_lvl (ADDRSIZE=4, AE_THRESH=2): occupancy model plus directed pins.
module tb_rptr_empty_lvl;

    localparam int AW   = 4;
    localparam int PMOD = 32;
    localparam int AE   = 2;
`ifdef RPTR_UNDERFLOW_EN
    localparam bit UF_EN = 1'b1;
`else
    localparam bit UF_EN = 1'b0;
`endif

    logic          rclk = 1'b0;
    logic          rrst_n = 1'b0;
    logic          rinc = 1'b0;
    logic [AW:0]   wptr_sync = '0;
    logic          uflow_clr = 1'b0;
    logic [AW:0]   rptr;
    logic [AW-1:0] raddr;
    logic          rd_fire;
    logic          empty;
    logic          almost_empty;
    logic [AW:0]   rlevel;
    logic          uflow;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: count of reads consumed and writes published, both modulo 2*DEPTH.
    int m_w     = 0;
    int m_r     = 0;
    int m_level = 0;
    bit m_empty = 1'b1;
    bit m_ae    = 1'b1;
    bit m_uflow = 1'b0;

    rptr_empty_lvl #(.ADDRSIZE(AW), .AE_THRESH(AE)) dut (
        .rclk         (rclk),
        .rrst_n       (rrst_n),
        .rinc         (rinc),
        .wptr_sync    (wptr_sync),
        .uflow_clr    (uflow_clr),
        .rptr         (rptr),
        .raddr        (raddr),
        .rd_fire      (rd_fire),
        .empty        (empty),
        .almost_empty (almost_empty),
        .rlevel       (rlevel),
        .uflow        (uflow)
    );

    always #5 rclk = ~rclk;

    function automatic logic [AW:0] gray(input int b);
        logic [AW:0] x;
        x = b[AW:0];
        return x ^ (x >> 1);
    endfunction

    function automatic int mod_p(input int v);
        return ((v % PMOD) + PMOD) % PMOD;
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, actual, expected);
        end
    endtask

    task automatic set_w(input int w);
        m_w       = mod_p(w);
        wptr_sync = gray(m_w);
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge rclk);
            #1;
        end
    endtask

    // Reference: one accepted read per edge when not empty; flags follow the resulting occupancy.
    always @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            m_r = 0; m_level = 0; m_empty = 1'b1; m_ae = 1'b1; m_uflow = 1'b0;
        end else begin
            if (UF_EN) begin
                if (rinc && m_empty) m_uflow = 1'b1;
                else if (uflow_clr)  m_uflow = 1'b0;
            end
            if (rinc && !m_empty) m_r = mod_p(m_r + 1);
            m_level = mod_p(m_w - m_r);
            m_empty = (m_level == 0);
            m_ae    = (m_level <= AE);
        end
    end

    always @(negedge rclk) begin
        check("rptr",         32'(rptr),         32'(gray(m_r)));
        check("raddr",        32'(raddr),        32'(m_r % 16));
        check("rd_fire",      32'(rd_fire),      32'(rinc && !m_empty));
        check("empty",        32'(empty),        32'(m_empty));
        check("almost_empty", 32'(almost_empty), 32'(m_ae));
        check("rlevel",       32'(rlevel),       32'(m_level));
        check("uflow",        32'(uflow),        32'(m_uflow));
    end

    initial begin
        #2_000_000;
        n_errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        logic [AW:0] wrap_seq [5];
        wrap_seq = '{5'b10000, 5'b00000, 5'b00001, 5'b00011, 5'b00010};

        // 1: reset, then reads against an empty FIFO change nothing
        set_w(0);
        step(2);
        rrst_n = 1'b1;
        check("t1_empty", 32'(empty), 32'd1);
        check("t1_ae",    32'(almost_empty), 32'd1);
        rinc = 1'b1;
        step(3);
        check("t1_rlevel", 32'(rlevel), 32'd0);
        check("t1_rptr",   32'(rptr),   32'd0);
        check("t1_raddr",  32'(raddr),  32'd0);
        check("t1_empty2", 32'(empty),  32'd1);
        rinc = 1'b0;

        // 2: five entries, single reads
        set_w(5);
        step();
        check("t2_rlevel0", 32'(rlevel), 32'd5);
        check("t2_ae0",     32'(almost_empty), 32'd0);
        for (int i = 0; i < 5; i++) begin
            check("t2_raddr", 32'(raddr), 32'(i));
            rinc = 1'b1;
            step();
            rinc = 1'b0;
            check("t2_rlevel", 32'(rlevel), 32'(4 - i));
            check("t2_ae",     32'(almost_empty), 32'((4 - i) <= 2));
        end
        check("t2_empty", 32'(empty), 32'd1);

        // 3: full FIFO drained
        rrst_n = 1'b0;
        set_w(0);
        step();
        rrst_n = 1'b1;
        set_w(16);
        step();
        check("t3_rlevel_full", 32'(rlevel), 32'd16);
        check("t3_empty0",      32'(empty),  32'd0);
        rinc = 1'b1;
        step(16);
        rinc = 1'b0;
        check("t3_rptr_end", 32'(rptr),   32'(5'b11000));
        check("t3_empty",    32'(empty),  32'd1);
        check("t3_rlevel",   32'(rlevel), 32'd0);

        // 4: advance to rbin=30, then read across the pointer wrap
        set_w(30);
        step();
        rinc = 1'b1;
        step(14);
        rinc = 1'b0;
        check("t4_rptr30", 32'(rptr), 32'(5'b10001));
        set_w(3);
        step();
        check("t4_rlevel_wrap", 32'(rlevel), 32'd5);
        for (int i = 0; i < 5; i++) begin
            rinc = 1'b1;
            step();
            check("t4_gray_seq", 32'(rptr), 32'(wrap_seq[i]));
        end
        rinc = 1'b0;
        check("t4_empty", 32'(empty), 32'd1);

        // 5: asynchronous reset in the middle of a burst at level 7
        set_w(13);
        step();
        rinc = 1'b1;
        step(3);
        check("t5_rlevel7", 32'(rlevel), 32'd7);
        #2;
        rrst_n = 1'b0;
        #1;
        check("t5_rptr",   32'(rptr),   32'd0);
        check("t5_raddr",  32'(raddr),  32'd0);
        check("t5_empty",  32'(empty),  32'd1);
        check("t5_ae",     32'(almost_empty), 32'd1);
        check("t5_rlevel", 32'(rlevel), 32'd0);
        check("t5_uflow",  32'(uflow),  32'd0);
        rinc = 1'b0;
        set_w(0);
        step();
        rrst_n = 1'b1;

        // 6: sticky underflow, clear, and set-beats-clear
        rinc = 1'b1;
        step();
        rinc = 1'b0;
        check("t6_set", 32'(uflow), 32'(UF_EN));
        step();
        check("t6_hold", 32'(uflow), 32'(UF_EN));
        uflow_clr = 1'b1;
        step();
        check("t6_clr", 32'(uflow), 32'd0);
        rinc = 1'b1;
        step();
        check("t6_set_wins", 32'(uflow), 32'(UF_EN));
        rinc = 1'b0;
        uflow_clr = 1'b0;

        // Random traffic: writer publishes within capacity, reader requests at random
        for (int c = 0; c < 3000; c++) begin
            int lvl;
            lvl = mod_p(m_w - m_r);
            rinc      = ($urandom_range(3) != 0);
            uflow_clr = ($urandom_range(7) == 0);
            if (lvl < 16 && $urandom_range(2) == 0)
                set_w(m_w + $urandom_range(16 - lvl, 1));
            step();
        end
        rinc = 1'b0;
        uflow_clr = 1'b0;
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
